// File: rtl/sr_latch_bank.sv
// Purpose : WIDTH independent clocked SR/JK flag channels with input glitch filtering,
//           configurable set=reset=1 resolution, sticky conflict flag and change strobe.
// Latency : FILT+1 rising edges from a stable input pair to q/qbar/changed/conflict.
// Backpressure: none; inputs are level samples and every output is a registered level/pulse.
//
// Ports:
//   clock          rising-edge clock for all state
//   reset_n        asynchronous active-low reset (q=RESET_Q, flags cleared)
//   set[W]         per-channel set request, active high
//   reset[W]       per-channel reset request, active high
//   clear_conflict per-channel write-1-to-clear for the conflict flag (unfiltered)
//   q / qbar       latched state and its registered complement
//   conflict       sticky: a qualified set=1/reset=1 pair was seen
//   changed        one-cycle pulse on the cycle q takes a new value

module sr_latch_bank #(
    parameter int              WIDTH   = 4,
    parameter int              FILT    = 2,
    parameter int              MODE    = 0,
    parameter logic [WIDTH-1:0] RESET_Q = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] reset,
    input  logic [WIDTH-1:0] clear_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] conflict,
    output logic [WIDTH-1:0] changed
);

    // FILT is at most 15, so a 4-bit count always fits.
    localparam logic [3:0] FILT_C  = 4'(FILT);
    localparam logic [3:0] FILT_M1 = 4'(FILT - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch

        logic [1:0] w_p;
        logic [3:0] w_cnt_nxt;
        logic       w_fire_nxt;
        logic       w_q_nxt;
        logic       w_conf_set;
        logic       w_conf_nxt;

        // r_p    : last sampled {set,reset}; also the pair that acts when r_fire is high
        // r_cnt  : consecutive edges r_p has been seen, saturating at FILT
        // r_fire : r_p reached FILT on the previous edge and acts on this one
        logic [1:0] r_p;
        logic [3:0] r_cnt;
        logic       r_fire;
        logic       r_q;
        logic       r_qbar;
        logic       r_conf;
        logic       r_chg;

        assign w_p = {set[i], reset[i]};

        // Qualification filter. A new pair restarts the count at 1; a repeated
        // pair advances it. The fire strobe is raised only on the edge where the
        // count first reaches FILT, so a long hold acts exactly once and the
        // saturated count can never wrap into a second action.
        always_comb begin
            w_cnt_nxt  = 4'd1;
            w_fire_nxt = 1'b0;
            if (w_p == r_p) begin
                if (r_cnt != FILT_C) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
                w_fire_nxt = (r_cnt == FILT_M1);
            end else begin
                // With FILT=1 the first sample of a new pair already qualifies.
                w_fire_nxt = (FILT == 1);
            end
        end

        // Action on a qualified pair. 00 qualifying is a release with no effect.
        always_comb begin
            w_q_nxt    = r_q;
            w_conf_set = 1'b0;
            if (r_fire) begin
                case (r_p)
                    2'b10: w_q_nxt = 1'b1;
                    2'b01: w_q_nxt = 1'b0;
                    2'b11: begin
                        w_conf_set = 1'b1;
                        case (MODE)
                            0:       w_q_nxt = 1'b0;
                            1:       w_q_nxt = 1'b1;
                            2:       w_q_nxt = r_q;
                            default: w_q_nxt = ~r_q;
                        endcase
                    end
                    default: w_q_nxt = r_q;
                endcase
            end
        end

        // A conflict recorded on the same edge as a clear takes priority, so a
        // clear racing a fresh conflict never loses it.
        always_comb begin
            w_conf_nxt = r_conf;
            if (w_conf_set) begin
                w_conf_nxt = 1'b1;
            end else if (clear_conflict[i]) begin
                w_conf_nxt = 1'b0;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                // Filter restarts as "00 already qualified": nothing pending.
                r_p    <= 2'b00;
                r_cnt  <= FILT_C;
                r_fire <= 1'b0;
                r_q    <= RESET_Q[i];
                r_qbar <= ~RESET_Q[i];
                r_conf <= 1'b0;
                r_chg  <= 1'b0;
            end else begin
                r_p    <= w_p;
                r_cnt  <= w_cnt_nxt;
                r_fire <= w_fire_nxt;
                r_q    <= w_q_nxt;
                // Separate complement register keeps qbar glitch-free and
                // never equal to q, whatever the resolution mode does.
                r_qbar <= ~w_q_nxt;
                r_conf <= w_conf_nxt;
                r_chg  <= (w_q_nxt != r_q);
            end
        end

        assign q[i]        = r_q;
        assign qbar[i]     = r_qbar;
        assign conflict[i] = r_conf;
        assign changed[i]  = r_chg;

    end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Purpose : directed check of sr_latch_bank with WIDTH=4, FILT=3, RESET_Q=0101, one instance per MODE.
// Latency : stimulus changes 1ns after a rising edge; outputs checked at that same point.
// Backpressure: not applicable.

module tb_sr_latch_bank;

    logic       clock;
    logic       reset_n;
    logic [3:0] tb_set;
    logic [3:0] tb_reset;
    logic [3:0] tb_clr;

    logic [3:0] q_m    [4];
    logic [3:0] qbar_m [4];
    logic [3:0] conf_m [4];
    logic [3:0] chg_m  [4];

    int vectors     = 0;
    int miscompares = 0;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_latch_bank #(
            .WIDTH   (4),
            .FILT    (3),
            .MODE    (m),
            .RESET_Q (4'b0101)
        ) u_dut (
            .clock          (clock),
            .reset_n        (reset_n),
            .set            (tb_set),
            .reset          (tb_reset),
            .clear_conflict (tb_clr),
            .q              (q_m[m]),
            .qbar           (qbar_m[m]),
            .conflict       (conf_m[m]),
            .changed        (chg_m[m])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b1;
        tb_set   = 4'b0000;
        tb_reset = 4'b0000;
        tb_clr   = 4'b0000;

        // Asynchronous reset asserted mid-cycle, checked before any edge.
        #12;
        reset_n = 1'b0;
        #1;
        chk("rst_q",        q_m[0],    4'b0101);
        chk("rst_qbar",     qbar_m[0], 4'b1010);
        chk("rst_conflict", conf_m[0], 4'b0000);
        chk("rst_changed",  chg_m[0],  4'b0000);
        chk("rst_q_m3",     q_m[3],    4'b0101);
        chk("rst_qbar_m3",  qbar_m[3], 4'b1010);
        tick();
        tick();
        chk("rst_hold_q", q_m[1], 4'b0101);
        reset_n = 1'b1;

        // Qualified reset on ch0 brings q[0] low on the 4th edge.
        tb_reset = 4'b0001;
        tick();
        tick();
        tick();
        chk("rst0_before_q", q_m[0], 4'b0101);
        chk("rst0_before_chg", chg_m[0], 4'b0000);
        tb_reset = 4'b0000;
        tick();
        chk("rst0_q",    q_m[0],    4'b0100);
        chk("rst0_qbar", qbar_m[0], 4'b1011);
        chk("rst0_chg",  chg_m[0],  4'b0001);
        tick();
        chk("rst0_chg_end", chg_m[0], 4'b0000);

        // Two-edge set glitch on ch0 is ignored.
        tb_set = 4'b0001;
        tick();
        tick();
        tb_set = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("glitch_q",   q_m[0],   4'b0100);
            chk("glitch_chg", chg_m[0], 4'b0000);
        end

        // Three-edge set on ch0: q[0]=1 at edge 4, one-cycle changed.
        tb_set = 4'b0001;
        tick();
        tick();
        tick();
        chk("set0_before_q", q_m[0], 4'b0100);
        tb_set = 4'b0000;
        tick();
        chk("set0_q",   q_m[0],   4'b0101);
        chk("set0_chg", chg_m[0], 4'b0001);
        tick();
        chk("set0_chg_end", chg_m[0], 4'b0000);
        chk("set0_q_hold",  q_m[0],   4'b0101);

        // 11 on ch1 held 10 edges: one action only.
        tb_set   = 4'b0010;
        tb_reset = 4'b0010;
        tick();
        tick();
        tick();
        chk("tog_before_q",    q_m[3],    4'b0101);
        chk("tog_before_conf", conf_m[3], 4'b0000);
        tick();
        chk("tog_q_m3",    q_m[3],    4'b0111);
        chk("tog_qbar_m3", qbar_m[3], 4'b1000);
        chk("tog_chg_m3",  chg_m[3],  4'b0010);
        chk("tog_conf_m3", conf_m[3], 4'b0010);
        chk("c11_q_m0",    q_m[0],    4'b0101);
        chk("c11_chg_m0",  chg_m[0],  4'b0000);
        chk("c11_conf_m0", conf_m[0], 4'b0010);
        chk("c11_q_m1",    q_m[1],    4'b0111);
        chk("c11_q_m2",    q_m[2],    4'b0101);
        chk("c11_conf_m2", conf_m[2], 4'b0010);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("tog_hold_q",   q_m[3],   4'b0111);
            chk("tog_hold_chg", chg_m[3], 4'b0000);
        end
        tb_set   = 4'b0000;
        tb_reset = 4'b0000;
        tick();
        tick();
        tick();
        chk("tog_rel_q", q_m[3], 4'b0111);
        tb_set   = 4'b0010;
        tb_reset = 4'b0010;
        tick();
        tick();
        tick();
        chk("tog2_before_q", q_m[3], 4'b0111);
        tb_set   = 4'b0000;
        tb_reset = 4'b0000;
        tick();
        chk("tog2_q_m3",   q_m[3],   4'b0101);
        chk("tog2_chg_m3", chg_m[3], 4'b0010);
        chk("tog2_q_m1",   q_m[1],   4'b0111);
        chk("tog2_chg_m1", chg_m[1], 4'b0000);
        tick();
        tick();

        // 11 on ch2 from q=1, with clear_conflict[2] held across the
        // qualifying edge and the update edge: conflict must still be set.
        tb_set   = 4'b0100;
        tb_reset = 4'b0100;
        tick();
        tick();
        tb_clr = 4'b0100;
        tick();
        tb_set   = 4'b0000;
        tb_reset = 4'b0000;
        tick();
        tb_clr = 4'b0000;
        chk("res_q_m0",    q_m[0],    4'b0001);
        chk("res_q_m1",    q_m[1],    4'b0111);
        chk("res_q_m2",    q_m[2],    4'b0101);
        chk("res_q_m3",    q_m[3],    4'b0001);
        chk("res_chg_m0",  chg_m[0],  4'b0100);
        chk("res_chg_m1",  chg_m[1],  4'b0000);
        chk("res_chg_m2",  chg_m[2],  4'b0000);
        chk("res_qbar_m0", qbar_m[0], 4'b1110);
        chk("race_conf_m0", conf_m[0], 4'b0110);
        chk("race_conf_m1", conf_m[1], 4'b0110);
        chk("race_conf_m2", conf_m[2], 4'b0110);
        chk("race_conf_m3", conf_m[3], 4'b0110);

        // Later clear pulses take effect on the sampling edge.
        tb_clr = 4'b0100;
        tick();
        tb_clr = 4'b0000;
        chk("clr2_conf_m0", conf_m[0], 4'b0010);
        chk("clr2_conf_m1", conf_m[1], 4'b0010);
        tb_clr = 4'b0010;
        tick();
        tb_clr = 4'b0000;
        chk("clr1_conf_m2", conf_m[2], 4'b0000);
        tick();
        chk("clr_stays_m2", conf_m[2], 4'b0000);

        // Reset mid-qualification on ch3 discards the partial count.
        tb_set = 4'b1000;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_q",    q_m[0],    4'b0101);
        chk("mid_rst_conf", conf_m[3], 4'b0000);
        chk("mid_rst_chg",  chg_m[0],  4'b0000);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_early_q", q_m[0], 4'b0101);
        end
        tick();
        chk("mid_q",   q_m[0],   4'b1101);
        chk("mid_chg", chg_m[0], 4'b1000);
        tick();
        chk("mid_chg_end", chg_m[0], 4'b0000);

        // Redundant set with q[3] already 1: no change pulse.
        tb_set = 4'b0000;
        tick();
        tick();
        tick();
        tb_set = 4'b1000;
        tick();
        tick();
        tick();
        tb_set = 4'b0000;
        tick();
        chk("redund_q",   q_m[0],   4'b1101);
        chk("redund_chg", chg_m[0], 4'b0000);
        tick();
        chk("redund_chg2", chg_m[0], 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Parametrised, clocked, multi-channel set/reset storage bank. It replaces the cross-coupled gate-level SR latch with WIDTH synchronous SR/JK channels. Each channel adds:
- input pulse qualification (glitch filter)
- a selectable resolution for simultaneous set and reset
- a sticky conflict flag
- a change strobe

It sits between raw control/status strobes and the logic that consumes latched flags.

## Interface
- WIDTH, 4: number of independent channels (1..32).
- FILT, 2: consecutive sample edges an input pair must be held to qualify (1..15).
- MODE, 0: action for qualified set=1/reset=1. 0 = reset wins (q<=0), 1 = set wins (q<=1), 2 = hold, 3 = toggle (JK).
- RESET_Q, {WIDTH{1'b0}}: per-channel q value while reset is asserted.

Ports (name, direction, width, meaning):
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- set  in  WIDTH  per-channel set request, active high, sampled synchronously.
- reset  in  WIDTH  per-channel reset request, active high, sampled synchronously.
- clear_conflict  in  WIDTH  per-channel write-1-to-clear pulse for conflict.
- q  out  WIDTH  latched state, registered.
- qbar  out  WIDTH  always exactly ~q, registered. Never equal to q, including under conflict.
- conflict  out  WIDTH  sticky: a qualified set=1/reset=1 pair was seen.
- changed  out  WIDTH  one-cycle pulse on the cycle q[i] takes a new value.

## Operation
- Channels are fully independent. Per channel the input pair is P = {set[i], reset[i]}.
- Qualification:
  - P is qualified when the same value is sampled on FILT consecutive rising edges.
  - A change of P at any edge restarts the count; the new value counts as its first edge.
  - Pulses shorter than FILT edges are ignored entirely.
- Single action per qualification:
  - A qualified P acts exactly once.
  - Holding P afterwards does nothing further.
  - P must change and requalify before it can act again. P=00 qualifying is a valid "release" that performs no action.
- Actions by qualified P:
  - 10: q<=1.
  - 01: q<=0.
  - 00: no change.
  - 11: per MODE. Also sets conflict[i] in every mode.
- MODE 3 toggle applies only to 11; 10 and 01 behave as set and reset.
- changed[i]:
  - Asserted for one cycle in the same cycle q[i] updates, and only if the new q differs from the old.
  - Set-while-already-1 produces no pulse.
- conflict[i]:
  - Cleared by clear_conflict[i]=1 on an edge.
  - Simultaneous qualified 11 and clear_conflict[i]: set wins, conflict stays 1.
- MODE, FILT and RESET_Q are elaboration-time constants. No run-time mode change.

## Timing
- Reset (reset_n low, asynchronous, immediate):
  - q=RESET_Q, qbar=~RESET_Q, conflict=0, changed=0.
  - Filter state is cleared to "P=00 qualified".
- Reset release: first counting edge is the first rising edge with reset_n high. Deassertion is assumed synchronised externally.
- Latency:
  - P presented before edge E and held through edge E+FILT-1 qualifies at edge E+FILT-1.
  - q, qbar, changed and conflict update at edge E+FILT, so the latency is FILT+1 edges.
  - Example: FILT=1 gives a 2-edge latency (sample register, then state register).
- Reset mid-qualification: the partial count is discarded. An input still held after release needs a full FILT edges again.
- Count saturates; an arbitrarily long hold never wraps into a second action.
- clear_conflict takes effect at the edge it is sampled (no filtering); conflict reads 0 the following cycle.
- Throughput: a channel can act at most once every FILT edges (alternating P values, each held FILT edges).

## Test plan
Default configuration for all cases: WIDTH=4, FILT=3.
- Reset values: RESET_Q=4'b0101, drive reset_n low mid-cycle -> q=0101, qbar=1010, conflict=0, changed=0 immediately, without waiting for a clock edge.
- Qualification and glitch rejection:
  - set[0] high for 2 edges, then low -> q[0] stays 0, changed[0] stays 0.
  - set[0] high for 3 edges -> q[0]=1 at edge 4, changed[0] high for exactly one cycle.
- Single action: MODE=3, set=reset=1 on ch1 held 10 edges -> q[1] toggles once at edge 4, conflict[1]=1. Release to 00 (3 edges) then 11 again (3 edges) -> second toggle.
- Conflict resolution: run MODE=0, 1 and 2, each with qualified 11 on ch2 from q=1 -> q[2] = 0, 1 and 1 respectively; conflict[2]=1 in all three.
- Clear race: clear_conflict[2] pulsed on the same edge ch2's 11 qualifies -> conflict[2]=1. A clear pulse on a later edge -> conflict[2]=0 the next cycle.
- Reset mid-operation: ch3 set held; reset_n pulsed low after 2 edges; set kept high -> q[3] rises 4 edges after release, not earlier. Redundant set with q already 1 gives no changed pulse.
